// File: rtl/register_status_file_if.sv
// Dispatch/commit/lookup bundle between the dispatch stage, the ROB and the register status file.
// master: dispatch + ROB side; slave: the register status file.
interface register_status_file_if #(
    parameter int unsigned NREG  = 32,
    parameter int unsigned TAG_W = 5,
    parameter int unsigned XLEN  = 32
);
    localparam int unsigned AW = $clog2(NREG);

    logic             disp_we;
    logic [AW-1:0]    disp_rd;
    logic [TAG_W-1:0] disp_tag;

    logic [AW-1:0]    rs1_addr;
    logic [AW-1:0]    rs2_addr;
    logic [XLEN-1:0]  rs1_value;
    logic [XLEN-1:0]  rs2_value;
    logic             rs1_busy;
    logic             rs2_busy;
    logic [TAG_W-1:0] rs1_tag;
    logic [TAG_W-1:0] rs2_tag;

    logic             commit_valid;
    logic [AW-1:0]    commit_rd;
    logic [XLEN-1:0]  commit_value;
    logic [TAG_W-1:0] commit_tag;

    logic             flush;
    logic [5:0]       busy_count;

    modport master (
        output disp_we, disp_rd, disp_tag,
        output rs1_addr, rs2_addr,
        output commit_valid, commit_rd, commit_value, commit_tag,
        output flush,
        input  rs1_value, rs2_value, rs1_busy, rs2_busy, rs1_tag, rs2_tag,
        input  busy_count
    );

    modport slave (
        input  disp_we, disp_rd, disp_tag,
        input  rs1_addr, rs2_addr,
        input  commit_valid, commit_rd, commit_value, commit_tag,
        input  flush,
        output rs1_value, rs2_value, rs1_busy, rs2_busy, rs1_tag, rs2_tag,
        output busy_count
    );
endinterface

// File: rtl/register_status_file.sv
// Architectural register file with per-register rename status (busy + ROB tag).
// Commits retire values; dispatch marks destinations pending; two combinational source lookups.
module register_status_file #(
    parameter int unsigned NREG  = 32,
    parameter int unsigned TAG_W = 5,
    parameter int unsigned XLEN  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    register_status_file_if.slave   bus
);
    localparam int unsigned AW = $clog2(NREG);

    logic [XLEN-1:0]  value_q [NREG];
    logic [XLEN-1:0]  value_d [NREG];
    logic [NREG-1:0]  busy_q;
    logic [NREG-1:0]  busy_d;
    logic [TAG_W-1:0] tag_q   [NREG];
    logic [TAG_W-1:0] tag_d   [NREG];
    logic [5:0]       busy_count_q;
    logic [5:0]       busy_count_d;

    logic commit_hit;
    logic disp_hit;

    assign commit_hit = bus.commit_valid && (bus.commit_rd != '0);
    assign disp_hit   = bus.disp_we && (bus.disp_rd != '0) && !bus.flush;

    // Flush and dispatch are applied after the commit so they override its busy-clear.
    always_comb begin
        value_d = value_q;
        busy_d  = busy_q;
        tag_d   = tag_q;
        if (commit_hit) begin
            value_d[bus.commit_rd] = bus.commit_value;
            if (busy_q[bus.commit_rd] && (tag_q[bus.commit_rd] == bus.commit_tag)) begin
                busy_d[bus.commit_rd] = 1'b0;
            end
        end
        if (bus.flush) begin
            busy_d = '0;
            for (int unsigned i = 0; i < NREG; i++) begin
                tag_d[i] = '0;
            end
        end else if (disp_hit) begin
            busy_d[bus.disp_rd] = 1'b1;
            tag_d[bus.disp_rd]  = bus.disp_tag;
        end
    end

    always_comb begin
        busy_count_d = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            busy_count_d = busy_count_d + 6'(busy_d[AW'(i)]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            value_q      <= value_d;
            busy_q       <= busy_d;
            tag_q        <= tag_d;
            busy_count_q <= busy_count_d;
        end
    end

    // Lookups see a same-cycle commit (value and busy-clear) but never a same-cycle dispatch.
    logic [AW-1:0]    rd_addr  [2];
    logic [XLEN-1:0]  rd_value [2];
    logic             rd_busy  [2];
    logic [TAG_W-1:0] rd_tag   [2];

    assign rd_addr[0] = bus.rs1_addr;
    assign rd_addr[1] = bus.rs2_addr;

    always_comb begin
        for (int unsigned p = 0; p < 2; p++) begin
            rd_value[p] = '0;
            rd_busy[p]  = 1'b0;
            rd_tag[p]   = '0;
            if (rd_addr[p] != '0) begin
                rd_value[p] = value_q[rd_addr[p]];
                rd_busy[p]  = busy_q[rd_addr[p]];
                rd_tag[p]   = tag_q[rd_addr[p]];
                if (commit_hit && (bus.commit_rd == rd_addr[p])) begin
                    rd_value[p] = bus.commit_value;
                    if (tag_q[rd_addr[p]] == bus.commit_tag) begin
                        rd_busy[p] = 1'b0;
                    end
                end
            end
        end
    end

    assign bus.rs1_value  = rd_value[0];
    assign bus.rs1_busy   = rd_busy[0];
    assign bus.rs1_tag    = rd_tag[0];
    assign bus.rs2_value  = rd_value[1];
    assign bus.rs2_busy   = rd_busy[1];
    assign bus.rs2_tag    = rd_tag[1];
    assign bus.busy_count = busy_count_q;

endmodule

// File: tb/tb_register_status_file.sv
// Table-driven self-checking bench for register_status_file with a scoreboard queue
// of expected lookup results, plus hand sequences for saturation and mid-run reset.
module tb_register_status_file;
    logic clk;
    logic rst_n;

    register_status_file_if #(.NREG(32), .TAG_W(5), .XLEN(32)) bus ();

    register_status_file #(.NREG(32), .TAG_W(5), .XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        fl;
        logic        dwe;
        logic [4:0]  drd;
        logic [4:0]  dtag;
        logic        cv;
        logic [4:0]  crd;
        logic [31:0] cval;
        logic [4:0]  ctag;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] ev1;
        logic        eb1;
        logic [4:0]  et1;
        logic [31:0] ev2;
        logic        eb2;
        logic [4:0]  et2;
        logic [5:0]  ecnt;
        logic        tchk;
    } vec_t;

    vec_t tbl [25];
    vec_t sb [$];
    int   checks;
    int   failures;
    int   step;

    function automatic vec_t mk(
        input logic rs, input logic fl, input logic dwe, input logic [4:0] drd, input logic [4:0] dtag,
        input logic cv, input logic [4:0] crd, input logic [31:0] cval, input logic [4:0] ctag,
        input logic [4:0] a1, input logic [4:0] a2,
        input logic [31:0] ev1, input logic eb1, input logic [4:0] et1,
        input logic [31:0] ev2, input logic eb2, input logic [4:0] et2,
        input logic [5:0] ecnt);
        vec_t v;
        v.rst_n = rs;  v.fl = fl;    v.dwe = dwe;   v.drd = drd; v.dtag = dtag;
        v.cv = cv;     v.crd = crd;  v.cval = cval; v.ctag = ctag;
        v.a1 = a1;     v.a2 = a2;
        v.ev1 = ev1;   v.eb1 = eb1;  v.et1 = et1;
        v.ev2 = ev2;   v.eb2 = eb2;  v.et2 = et2;
        v.ecnt = ecnt; v.tchk = 1'b0;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL step%0d %s: got %h expected %h", step, nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst_n            = v.rst_n;
        bus.flush        = v.fl;
        bus.disp_we      = v.dwe;
        bus.disp_rd      = v.drd;
        bus.disp_tag     = v.dtag;
        bus.commit_valid = v.cv;
        bus.commit_rd    = v.crd;
        bus.commit_value = v.cval;
        bus.commit_tag   = v.ctag;
        bus.rs1_addr     = v.a1;
        bus.rs2_addr     = v.a2;
        sb.push_back(v);
    endtask

    task automatic check_out();
        vec_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL step%0d scoreboard: got empty queue expected entry", step);
            return;
        end
        e = sb.pop_front();
        chk("rs1_value", bus.rs1_value, e.ev1);
        chk("rs1_busy", 32'(bus.rs1_busy), 32'(e.eb1));
        if (e.eb1 || e.a1 == 5'd0 || e.tchk) chk("rs1_tag", 32'(bus.rs1_tag), 32'(e.et1));
        chk("rs2_value", bus.rs2_value, e.ev2);
        chk("rs2_busy", 32'(bus.rs2_busy), 32'(e.eb2));
        if (e.eb2 || e.a2 == 5'd0 || e.tchk) chk("rs2_tag", 32'(bus.rs2_tag), 32'(e.et2));
        chk("busy_count", 32'(bus.busy_count), 32'(e.ecnt));
    endtask

    // Drive on the falling edge, compare 2 ns later, then let the rising edge commit.
    task automatic run_vec(input vec_t v);
        drive(v);
        #2;
        check_out();
        step++;
        @(negedge clk);
    endtask

    logic [31:0] busy_m;
    vec_t        v;

    initial begin
        checks   = 0;
        failures = 0;
        step     = 0;
        rst_n    = 1'b0;
        bus.flush = 1'b0; bus.disp_we = 1'b0; bus.disp_rd = '0; bus.disp_tag = '0;
        bus.commit_valid = 1'b0; bus.commit_rd = '0; bus.commit_value = '0; bus.commit_tag = '0;
        bus.rs1_addr = '0; bus.rs2_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        //             rs fl dw drd dtg cv crd cval           ctg a1 a2  ev1            eb1 et1  ev2            eb2 et2 cnt
        tbl[0]  = mk(1, 0, 0, 0,  0,  0, 0, 32'h0,         0,  5, 0,  32'h0,         0, 0,   32'h0,         0, 0,  0);
        tbl[1]  = mk(1, 0, 1, 3,  4,  0, 0, 32'h0,         0,  3, 0,  32'h0,         0, 0,   32'h0,         0, 0,  0);
        tbl[2]  = mk(1, 0, 0, 0,  0,  0, 0, 32'h0,         0,  3, 0,  32'h0,         1, 4,   32'h0,         0, 0,  1);
        tbl[3]  = mk(1, 0, 0, 0,  0,  1, 3, 32'hDEADBEEF,  4,  3, 0,  32'hDEADBEEF,  0, 0,   32'h0,         0, 0,  1);
        tbl[4]  = mk(1, 0, 0, 0,  0,  0, 0, 32'h0,         0,  3, 0,  32'hDEADBEEF,  0, 0,   32'h0,         0, 0,  0);
        tbl[5]  = mk(1, 0, 1, 7,  1,  0, 0, 32'h0,         0,  7, 0,  32'h0,         0, 0,   32'h0,         0, 0,  0);
        tbl[6]  = mk(1, 0, 1, 7,  2,  0, 0, 32'h0,         0,  7, 0,  32'h0,         1, 1,   32'h0,         0, 0,  1);
        tbl[7]  = mk(1, 0, 0, 0,  0,  1, 7, 32'h11,        1,  7, 0,  32'h11,        1, 2,   32'h0,         0, 0,  1);
        tbl[8]  = mk(1, 0, 0, 0,  0,  0, 0, 32'h0,         0,  7, 3,  32'h11,        1, 2,   32'hDEADBEEF,  0, 0,  1);
        tbl[9]  = mk(1, 0, 1, 9,  6,  1, 9, 32'h55,        0,  9, 0,  32'h55,        0, 0,   32'h0,         0, 0,  1);
        tbl[10] = mk(1, 0, 0, 0,  0,  0, 0, 32'h0,         0,  9, 7,  32'h55,        1, 6,   32'h11,        1, 2,  2);
        tbl[11] = mk(1, 0, 0, 0,  0,  1, 7, 32'h22,        2,  7, 9,  32'h22,        0, 0,   32'h55,        1, 6,  2);
        tbl[12] = mk(1, 0, 1, 9,  8,  1, 9, 32'h66,        6,  9, 0,  32'h66,        0, 0,   32'h0,         0, 0,  1);
        tbl[13] = mk(1, 0, 0, 0,  0,  0, 0, 32'h0,         0,  9, 7,  32'h66,        1, 8,   32'h22,        0, 0,  1);
        tbl[14] = mk(1, 0, 1, 1,  0,  0, 0, 32'h0,         0,  1, 9,  32'h0,         0, 0,   32'h66,        1, 8,  1);
        tbl[15] = mk(1, 0, 1, 2,  1,  0, 0, 32'h0,         0,  1, 2,  32'h0,         1, 0,   32'h0,         0, 0,  2);
        tbl[16] = mk(1, 0, 1, 3,  2,  0, 0, 32'h0,         0,  2, 3,  32'h0,         1, 1,   32'hDEADBEEF,  0, 0,  3);
        tbl[17] = mk(1, 1, 1, 4,  3,  1, 1, 32'h1000,      0,  1, 4,  32'h1000,      0, 0,   32'h0,         0, 0,  4);
        tbl[18] = mk(1, 0, 0, 0,  0,  0, 0, 32'h0,         0,  1, 4,  32'h1000,      0, 0,   32'h0,         0, 0,  0);
        tbl[19] = mk(1, 0, 0, 0,  0,  0, 0, 32'h0,         0,  3, 9,  32'hDEADBEEF,  0, 0,   32'h66,        0, 0,  0);
        tbl[19].tchk = 1'b1;
        tbl[20] = mk(1, 0, 1, 5,  9,  0, 0, 32'h0,         0,  5, 0,  32'h0,         0, 0,   32'h0,         0, 0,  0);
        tbl[21] = mk(1, 0, 1, 5, 10,  0, 0, 32'h0,         0,  5, 5,  32'h0,         1, 9,   32'h0,         1, 9,  1);
        tbl[22] = mk(1, 0, 0, 0,  0,  0, 0, 32'h0,         0,  5, 0,  32'h0,         1, 10,  32'h0,         0, 0,  1);
        tbl[23] = mk(1, 0, 1, 0,  7,  1, 0, 32'hFFFFFFFF,  7,  0, 0,  32'h0,         0, 0,   32'h0,         0, 0,  1);
        tbl[24] = mk(1, 0, 0, 0,  0,  0, 0, 32'h0,         0,  0, 0,  32'h0,         0, 0,   32'h0,         0, 0,  1);

        for (int i = 0; i < 25; i++) begin
            run_vec(tbl[i]);
        end

        // Fill every register; the count must top out at 31 and a re-dispatch must not bump it.
        busy_m = 32'h0000_0020;
        for (int r = 1; r < 32; r++) begin
            run_vec(mk(1, 0, 1, 5'(r), 5'(r), 0, 0, 32'h0, 0, 0, 0,
                       32'h0, 0, 0, 32'h0, 0, 0, 6'($countones(busy_m))));
            busy_m[r] = 1'b1;
        end
        run_vec(mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 31, 5, 32'h0, 1, 31, 32'h0, 1, 5, 31));
        run_vec(mk(1, 0, 1, 5, 20, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 31));
        run_vec(mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 5, 3, 32'h0, 1, 20, 32'hDEADBEEF, 1, 3, 31));

        // Reset in the same cycle as flush, commit and dispatch: nothing but reset may survive.
        run_vec(mk(0, 1, 1, 6, 6, 1, 6, 32'hAB, 6, 6, 3, 32'hAB, 0, 0, 32'hDEADBEEF, 1, 3, 31));
        v = mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 6, 3, 32'h0, 0, 0, 32'h0, 0, 0, 0);
        v.tchk = 1'b1;
        run_vec(v);
        run_vec(mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 9, 1, 32'h0, 0, 0, 32'h0, 0, 0, 0));

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
